// File: rtl/tm_step_engine.sv
// Turing-machine step engine: drives {state, symbol} to the transition table and applies the returned entry.
// Optional step budget enabled by defining TM_STEP_LIMIT_EN.
module tm_step_engine #(
  parameter int unsigned             STATE_WIDTH = 14,
  parameter int unsigned             HEAD_WIDTH  = 8,
  parameter logic [STATE_WIDTH-1:0]  START_STATE = '0,
  parameter logic [STATE_WIDTH-1:0]  HALT_STATE  = '1,
  parameter int unsigned             MAX_STEPS   = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [HEAD_WIDTH-1:0]  head_init,
  input  logic                   tape_we,
  input  logic [HEAD_WIDTH-1:0]  tape_waddr,
  input  logic                   tape_wdata,
  input  logic [HEAD_WIDTH-1:0]  tape_raddr,
  output logic                   tape_rdata,
  output logic [STATE_WIDTH:0]   mem_addr,
  input  logic [15:0]            mem_rdata,
  output logic                   busy,
  output logic                   done,
  output logic                   halted,
  output logic                   fault,
  output logic                   timeout,
  output logic [HEAD_WIDTH-1:0]  head,
  output logic [31:0]            step_count
);

  localparam int unsigned TAPE_LEN = 2**HEAD_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]             fsm;
  logic [STATE_WIDTH-1:0] cur_state;
  logic [TAPE_LEN-1:0]    tape;

  logic [13:0]            ns_field;
  logic                   wr_sym;
  logic                   mv_right;
  logic [STATE_WIDTH-1:0] next_state;
  logic                   exec_halt;
  logic                   exec_fault;
  logic                   exec_timeout;
  logic [HEAD_WIDTH-1:0]  head_next;
  logic [31:0]            step_inc;

  assign ns_field   = mem_rdata[15:2];
  assign wr_sym     = mem_rdata[1];
  assign mv_right   = mem_rdata[0];
  assign next_state = STATE_WIDTH'(ns_field);

  assign tape_rdata = tape[tape_raddr];
  assign mem_addr   = {cur_state, tape[head]};
  assign busy       = (fsm == S_FETCH) || (fsm == S_EXEC);
  assign done       = (fsm == S_DONE);

  always_comb begin
    exec_halt    = (next_state == HALT_STATE);
    exec_fault   = mv_right ? (head == '1) : (head == '0);
    head_next    = head;
    if (!exec_fault)
      head_next = mv_right ? head + HEAD_WIDTH'(1) : head - HEAD_WIDTH'(1);
    step_inc     = (step_count == '1) ? step_count : step_count + 32'd1;
    exec_timeout = 1'b0;
`ifdef TM_STEP_LIMIT_EN
    exec_timeout = !exec_halt && !exec_fault && (step_inc == MAX_STEPS);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= S_IDLE;
      cur_state  <= START_STATE;
      head       <= '0;
      tape       <= '0;
      step_count <= '0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE, S_DONE: begin
          // Tape write lands before the first FETCH when paired with start.
          if (tape_we)
            tape[tape_waddr] <= tape_wdata;
          if (start) begin
            cur_state  <= START_STATE;
            head       <= head_init;
            step_count <= '0;
            halted     <= (START_STATE == HALT_STATE);
            fault      <= 1'b0;
            fsm        <= (START_STATE == HALT_STATE) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: fsm <= S_EXEC;
        S_EXEC: begin
          tape[head] <= wr_sym;
          cur_state  <= next_state;
          step_count <= step_inc;
          head       <= head_next;
          halted     <= exec_halt;
          fault      <= exec_fault;
          fsm        <= (exec_halt || exec_fault || exec_timeout) ? S_DONE : S_FETCH;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

`ifdef TM_STEP_LIMIT_EN
  logic timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      timeout_q <= 1'b0;
    else if ((fsm == S_IDLE || fsm == S_DONE) && start)
      timeout_q <= 1'b0;
    else if (fsm == S_EXEC)
      timeout_q <= exec_timeout;
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tm_step_engine.sv
// Bench for tm_step_engine: directed scenarios plus random transition tables checked against a step-level model.
`timescale 1ns/1ps
module tb_tm_step_engine;

  localparam int SW  = 14;
  localparam int HW  = 8;
  localparam int TL  = 256;
  localparam int LIM = 300;
  localparam logic [SW-1:0] HALT = '1;
`ifdef TM_STEP_LIMIT_EN
  localparam int MAXS = 10;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          tape_we = 1'b0;
  logic          tape_wdata = 1'b0;
  logic [HW-1:0] head_init = '0;
  logic [HW-1:0] tape_waddr = '0;
  logic [HW-1:0] tape_raddr = '0;
  logic          tape_rdata;
  logic [SW:0]   mem_addr;
  logic [15:0]   mem_rdata = '0;
  logic          busy, done, halted, fault, timeout;
  logic [HW-1:0] head;
  logic [31:0]   step_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [15:0]   tbl [0:32767];
  logic [TL-1:0] mtape;
  int            m_steps, m_head, m_state;
  logic          m_halt, m_fault, m_to, m_end;

  tm_step_engine #(
    .STATE_WIDTH (SW),
    .HEAD_WIDTH  (HW),
    .MAX_STEPS   (10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .head_init  (head_init),
    .tape_we    (tape_we),
    .tape_waddr (tape_waddr),
    .tape_wdata (tape_wdata),
    .tape_raddr (tape_raddr),
    .tape_rdata (tape_rdata),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .halted     (halted),
    .fault      (fault),
    .timeout    (timeout),
    .head       (head),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  // Transition memory with one cycle of read latency.
  always @(posedge clk) mem_rdata <= tbl[mem_addr];

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [TL-1:0] got, input logic [TL-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ent(input int ns, input logic ws, input logic mv);
    logic [13:0] s;
    s = 14'(ns);
    return {s, ws, mv};
  endfunction

  task automatic clear_table();
    foreach (tbl[i]) tbl[i] = '0;
  endtask

  // Step-level machine: look up, write, change state, move; stop on halt/fault/budget.
  task automatic model_run(input int h0);
    int h, st;
    logic [15:0] e;
    h = h0; st = 0;
    m_steps = 0; m_halt = 0; m_fault = 0; m_to = 0; m_end = 0;
    while (!m_end && m_steps < LIM) begin
      e = tbl[st * 2 + int'(mtape[h])];
      mtape[h] = e[1];
      st = int'(e[15:2]);
      m_steps++;
      if (e[0]) begin
        if (h == TL - 1) m_fault = 1; else h++;
      end else begin
        if (h == 0) m_fault = 1; else h--;
      end
      m_halt = (st == int'(HALT));
      m_end  = m_halt || m_fault;
`ifdef TM_STEP_LIMIT_EN
      if (!m_end && m_steps == MAXS) begin
        m_to = 1; m_end = 1;
      end
`endif
    end
    m_head = h; m_state = st;
  endtask

  task automatic load_tape(input logic [TL-1:0] v);
    for (int i = 0; i < TL; i++) begin
      if (v[i] !== mtape[i]) begin
        @(negedge clk);
        tape_we = 1'b1; tape_waddr = HW'(i); tape_wdata = v[i];
      end
    end
    @(negedge clk);
    tape_we = 1'b0;
    mtape = v;
  endtask

  task automatic read_tape(output logic [TL-1:0] v);
    for (int i = 0; i < TL; i++) begin
      tape_raddr = HW'(i);
      #1;
      v[i] = tape_rdata;
    end
  endtask

  task automatic do_run(input int h0, input int pulse, input logic pre_we,
                        input int pre_addr, input logic pre_data, input string tag);
    int cyc;
    logic [TL-1:0] v;
    if (pre_we) mtape[pre_addr] = pre_data;
    model_run(h0);
    @(negedge clk);
    head_init = HW'(h0); start = 1'b1;
    if (pre_we) begin
      tape_we = 1'b1; tape_waddr = HW'(pre_addr); tape_wdata = pre_data;
    end
    @(negedge clk);
    start = 1'b0; tape_we = 1'b0;
    cyc = 0;
    if (m_end) begin
      while (!done && cyc < 2 * LIM + 8) begin
        @(posedge clk); #1; cyc++;
        if (pulse != 0 && cyc == pulse) begin
          start = 1'b1; tape_we = 1'b1; tape_waddr = 8'd9; tape_wdata = 1'b1;
        end else if (pulse != 0 && cyc == pulse + 1) begin
          start = 1'b0; tape_we = 1'b0;
        end
      end
      start = 1'b0; tape_we = 1'b0;
      check({tag, " cycles"}, TL'(cyc), TL'(2 * m_steps));
      check({tag, " done"}, TL'(done), TL'(1));
      check({tag, " busy"}, TL'(busy), TL'(0));
      check({tag, " halted"}, TL'(halted), TL'(m_halt));
      check({tag, " fault"}, TL'(fault), TL'(m_fault));
      check({tag, " timeout"}, TL'(timeout), TL'(m_to));
      check({tag, " head"}, TL'(head), TL'(m_head));
      check({tag, " steps"}, TL'(step_count), TL'(m_steps));
      check({tag, " mem_addr"}, TL'(mem_addr), TL'({14'(m_state), mtape[m_head]}));
      read_tape(v);
      check({tag, " tape"}, v, mtape);
    end else begin
      repeat (2 * LIM) begin
        @(posedge clk); #1; cyc++;
      end
      check({tag, " still busy"}, TL'(busy), TL'(1));
      check({tag, " steps"}, TL'(step_count), TL'(LIM));
      check({tag, " head"}, TL'(head), TL'(m_head));
      rst_n = 1'b0;
      #1;
      read_tape(v);
      check({tag, " tape after reset"}, v, '0);
      mtape = '0;
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    logic [TL-1:0] v;
    int r;
    clear_table();
    mtape = '0;

    repeat (3) @(negedge clk);
    check("rst busy", TL'(busy), '0);
    check("rst done", TL'(done), '0);
    check("rst halted", TL'(halted), '0);
    check("rst fault", TL'(fault), '0);
    check("rst timeout", TL'(timeout), '0);
    check("rst head", TL'(head), '0);
    check("rst steps", TL'(step_count), '0);
    check("rst mem_addr", TL'(mem_addr), '0);
    read_tape(v);
    check("rst tape", v, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single step
    tbl[0] = ent(int'(HALT), 1'b1, 1'b1);
    do_run(5, 0, 1'b0, 0, 1'b0, "single");
    check("single head6", TL'(head), TL'(6));
    check("single halted1", TL'(halted), TL'(1));

    // Unary increment
    load_tape(TL'(7));
    tbl[1] = ent(0, 1'b1, 1'b1);
    tbl[0] = ent(int'(HALT), 1'b1, 1'b1);
    do_run(0, 0, 1'b0, 0, 1'b0, "unary");
    check("unary steps4", TL'(step_count), TL'(4));
    read_tape(v);
    check("unary tape", v, TL'(15));

    // Left fault
    load_tape('0);
    tbl[0] = ent(7, 1'b1, 1'b0);
    do_run(0, 0, 1'b0, 0, 1'b0, "lfault");
    check("lfault flag", TL'(fault), TL'(1));
    check("lfault addr", TL'(mem_addr), TL'({14'd7, 1'b1}));

    // Busy gating, then write+start in the same DONE cycle
    load_tape(TL'(4));
    tbl[0] = ent(0, 1'b0, 1'b0);
    tbl[1] = ent(int'(HALT), 1'b1, 1'b0);
    do_run(10, 8, 1'b0, 0, 1'b0, "gating");
    check("gating steps9", TL'(step_count), TL'(9));
    read_tape(v);
    check("gating tape9", TL'(v[9]), TL'(0));
    do_run(1, 0, 1'b1, 1, 1'b1, "wr_start");
    check("wr_start halted", TL'(halted), TL'(1));
    check("wr_start steps1", TL'(step_count), TL'(1));

    // Async reset during EXEC of step 3
    load_tape('0);
    tbl[0] = ent(0, 1'b1, 1'b1);
    @(negedge clk);
    head_init = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("arst pre steps", TL'(step_count), TL'(2));
    check("arst pre busy", TL'(busy), TL'(1));
    rst_n = 1'b0;
    #1;
    check("arst busy", TL'(busy), '0);
    check("arst done", TL'(done), '0);
    check("arst steps", TL'(step_count), '0);
    check("arst head", TL'(head), '0);
    check("arst mem_addr", TL'(mem_addr), '0);
    read_tape(v);
    check("arst tape", v, '0);
    mtape = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst idle done", TL'(done), '0);

    // Step budget (runs to right-edge fault when no budget is built in)
    tbl[0] = ent(0, 1'b0, 1'b1);
    do_run(0, 0, 1'b0, 0, 1'b0, "limit");
`ifdef TM_STEP_LIMIT_EN
    check("limit timeout", TL'(timeout), TL'(1));
    check("limit steps10", TL'(step_count), TL'(10));
    check("limit head10", TL'(head), TL'(10));
`else
    check("limit none timeout", TL'(timeout), TL'(0));
    check("limit rfault", TL'(fault), TL'(1));
    check("limit head255", TL'(head), TL'(255));
`endif

    // Random tables over states 0..3 plus HALT
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < 8; k++) begin
        r = int'($urandom_range(0, 4));
        tbl[k] = ent((r == 4) ? int'(HALT) : r, 1'($urandom), 1'($urandom));
      end
      for (int w = 0; w < TL / 32; w++) v[w*32 +: 32] = $urandom;
      load_tape(v);
      do_run(int'($urandom_range(0, TL - 1)), 0, 1'b0, 0, 1'b0, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
